alu_rs: RTL
===========

Name: alu_rs

Overview:
- Reservation station directly upstream of the integer ALU in the out-of-order core.
- Buffers dispatched ALU/branch/address-generation micro-ops from the decoder until both source operands are available.
- Snoops the two common data buses (ALU result, load-store result) for missing operands.
- Issues at most one ready entry per cycle as a registered operand bundle: ena, op, rob tag, pc, A, B, imm.

Parameters:
- RS_SIZE, 8, number of entries; power of two, minimum 2.
- RS_IDX_W, 3, log2(RS_SIZE).
- DATA_W, 32, operand/data width (matches `DATA_WIDTH).
- ROB_W, 4, ROB tag width (matches `ROB_WIDTH).
- OP_W, 6, operation code width (matches `OPERATION_BUS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  ROB mispredict clear; synchronous.
- disp_valid  in  1  dispatch request.
- disp_op  in  OP_W  operation code.
- disp_pc  in  DATA_W  instruction pc.
- disp_imm  in  DATA_W  immediate.
- disp_rob_tag  in  ROB_W  destination ROB tag.
- disp_j_rdy  in  1  operand j already valid.
- disp_vj  in  DATA_W  operand j value.
- disp_qj  in  ROB_W  operand j producer tag.
- disp_k_rdy  in  1  operand k already valid.
- disp_vk  in  DATA_W  operand k value.
- disp_qk  in  ROB_W  operand k producer tag.
- full  out  1  no free entry; decoder must not dispatch.
- cdb_alu_valid  in  1  ALU broadcast valid.
- cdb_alu_tag  in  ROB_W  ALU broadcast tag.
- cdb_alu_data  in  DATA_W  ALU broadcast data.
- cdb_lsb_valid  in  1  load-store broadcast valid.
- cdb_lsb_tag  in  ROB_W  load-store broadcast tag.
- cdb_lsb_data  in  DATA_W  load-store broadcast data.
- alu_ena  out  1  issue valid to ALU.
- alu_op  out  OP_W  issued op.
- alu_rob_tag  out  ROB_W  issued tag.
- alu_pc  out  DATA_W  issued pc.
- alu_a  out  DATA_W  operand A (vj).
- alu_b  out  DATA_W  operand B (vk).
- alu_imm  out  DATA_W  issued imm.

Behaviour:
- Reset (async): all entry busy bits 0; all alu_* outputs 0; full 0.
- Entry state: busy, op, pc, imm, rob_tag, j_rdy/vj/qj, k_rdy/vk/qk.
- full is combinational from registered state: asserted when all RS_SIZE entries are busy.
- Dispatch:
  - disp_valid and !full writes the lowest-index free entry at the clock edge.
  - disp_valid while full is ignored; the entry array is unchanged.
- Wakeup, each edge, per busy entry and per operand:
  - If not ready and a valid CDB tag equals q, capture that CDB's data and set ready.
  - When both CDBs match (illegal by construction), ALU CDB wins.
- Dispatch bypass: a dispatched operand that is not ready but matches a valid CDB in the same cycle is written already ready, with the CDB data.
- Issue select:
  - Candidate = busy and j_rdy and k_rdy, using registered state only.
  - The lowest-index candidate is chosen.
  - At the edge, its fields are copied to the alu_* registers, alu_ena=1, and the entry is freed.
  - With no candidate: alu_ena=0 and the other alu_* outputs hold their values.
- Latency:
  - Dispatch at edge t with both operands ready → alu_ena at edge t+1.
  - Wakeup at edge t → issue at edge t+1 at earliest.
  - There is no combinational path from CDB to alu_*.
- Simultaneous dispatch and issue:
  - Both are allowed in the same cycle.
  - The entry freed by issue is not reusable until the next cycle (free search uses registered busy).
  - full deasserts the cycle after issue.
- Flush (sync, priority over everything):
  - All busy bits cleared and alu_ena=0 at that edge.
  - Dispatch and wakeup in the flush cycle are discarded.
- Reset mid-operation clears immediately regardless of clk.
- Ordering: no age ordering is guaranteed; ROB handles commit order.

Decomposition:
- Shared constant header (constant.v):
  - DATA_WIDTH, ROB_WIDTH, OPERATION_BUS.
  - ZERO_DATA, TRUE/FALSE.
  - A new RS_SIZE/RS_IDX_W pair for the ALU station.
- Sub-module rs_priority_enc:
  - Parameterised lowest-set-bit encoder (RS_SIZE in, index plus found-flag out).
  - Instantiated twice: free-slot search and ready-entry select.

Test Plan:
- Ready dispatch: dispatch ADD with vj=5, vk=7, both ready, tag 3 → alu_ena=1 next edge with alu_a=5, alu_b=7, alu_rob_tag=3; full=0 throughout.
- Delayed operand:
  - Dispatch with qj=2 not ready and vk=1 ready → alu_ena stays 0.
  - cdb_alu 2/0x10 → capture at that edge; alu_ena=1 with alu_a=0x10 one edge later.
- Dispatch bypass: dispatch with qk=6 not ready in the same cycle as cdb_lsb 6/0xABCD → issue next edge with alu_b=0xABCD.
- Fill and drain:
  - Eight non-ready dispatches → full=1; a ninth dispatch is ignored.
  - Broadcast their tags → eight issues in index order 0..7, one per cycle; full drops after the first issue.
- Flush with entries pending:
  - Four busy entries, one ready, plus a dispatch, all in the flush cycle → alu_ena=0 next edge.
  - full=0; later broadcasts produce no issue.
- Async reset: assert rst mid-cycle with alu_ena=1 → alu_ena and all alu_* outputs 0 before the next clk edge.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared widths, entry layout and operand snoop helper for the ALU reservation station
package alu_rs_pkg;

   localparam int DATA_WIDTH    = 32;
   localparam int ROB_WIDTH     = 4;
   localparam int OPERATION_BUS = 6;
   localparam int RS_SIZE       = 8;
   localparam int RS_IDX_W      = 3;

   localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef struct packed {
      logic                     busy;
      logic [OPERATION_BUS-1:0] op;
      logic [DATA_WIDTH-1:0]    pc;
      logic [DATA_WIDTH-1:0]    imm;
      logic [ROB_WIDTH-1:0]     rob_tag;
      logic                     j_rdy;
      logic [DATA_WIDTH-1:0]    vj;
      logic [ROB_WIDTH-1:0]     qj;
      logic                     k_rdy;
      logic [DATA_WIDTH-1:0]    vk;
      logic [ROB_WIDTH-1:0]     qk;
   } rs_entry_t;

   typedef struct packed {
      logic                  rdy;
      logic [DATA_WIDTH-1:0] val;
   } operand_t;

   // Resolve one operand against both result buses; the ALU bus wins a tie.
   function automatic operand_t snoop(
      input logic                  rdy,
      input logic [DATA_WIDTH-1:0] val,
      input logic [ROB_WIDTH-1:0]  q,
      input logic                  alu_valid,
      input logic [ROB_WIDTH-1:0]  alu_tag,
      input logic [DATA_WIDTH-1:0] alu_data,
      input logic                  lsb_valid,
      input logic [ROB_WIDTH-1:0]  lsb_tag,
      input logic [DATA_WIDTH-1:0] lsb_data
   );
      operand_t res;
      res.rdy = rdy;
      res.val = val;
      if (!rdy) begin
         if (alu_valid && (alu_tag == q)) begin
            res.rdy = TRUE;
            res.val = alu_data;
         end else if (lsb_valid && (lsb_tag == q)) begin
            res.rdy = TRUE;
            res.val = lsb_data;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/alu_rs_if.sv
// rtl/alu_rs_if.sv - dispatch, result-bus and issue signals of the ALU reservation station
interface alu_rs_if;
   import alu_rs_pkg::*;

   logic                     flush;

   logic                     disp_valid;
   logic [OPERATION_BUS-1:0] disp_op;
   logic [DATA_WIDTH-1:0]    disp_pc;
   logic [DATA_WIDTH-1:0]    disp_imm;
   logic [ROB_WIDTH-1:0]     disp_rob_tag;
   logic                     disp_j_rdy;
   logic [DATA_WIDTH-1:0]    disp_vj;
   logic [ROB_WIDTH-1:0]     disp_qj;
   logic                     disp_k_rdy;
   logic [DATA_WIDTH-1:0]    disp_vk;
   logic [ROB_WIDTH-1:0]     disp_qk;
   logic                     full;

   logic                     cdb_alu_valid;
   logic [ROB_WIDTH-1:0]     cdb_alu_tag;
   logic [DATA_WIDTH-1:0]    cdb_alu_data;
   logic                     cdb_lsb_valid;
   logic [ROB_WIDTH-1:0]     cdb_lsb_tag;
   logic [DATA_WIDTH-1:0]    cdb_lsb_data;

   logic                     alu_ena;
   logic [OPERATION_BUS-1:0] alu_op;
   logic [ROB_WIDTH-1:0]     alu_rob_tag;
   logic [DATA_WIDTH-1:0]    alu_pc;
   logic [DATA_WIDTH-1:0]    alu_a;
   logic [DATA_WIDTH-1:0]    alu_b;
   logic [DATA_WIDTH-1:0]    alu_imm;

   modport master (
      output flush,
      output disp_valid, disp_op, disp_pc, disp_imm, disp_rob_tag,
      output disp_j_rdy, disp_vj, disp_qj, disp_k_rdy, disp_vk, disp_qk,
      output cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
      output cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data,
      input  full,
      input  alu_ena, alu_op, alu_rob_tag, alu_pc, alu_a, alu_b, alu_imm
   );

   modport slave (
      input  flush,
      input  disp_valid, disp_op, disp_pc, disp_imm, disp_rob_tag,
      input  disp_j_rdy, disp_vj, disp_qj, disp_k_rdy, disp_vk, disp_qk,
      input  cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
      input  cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data,
      output full,
      output alu_ena, alu_op, alu_rob_tag, alu_pc, alu_a, alu_b, alu_imm
   );

endinterface

// File: rtl/alu_rs_priority_enc.sv
// rtl/alu_rs_priority_enc.sv - lowest-set-bit encoder with found flag
module rs_priority_enc #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         found
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - reservation station feeding the integer ALU
module alu_rs
   import alu_rs_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   alu_rs_if.slave  bus
);

   rs_entry_t            ent [RS_SIZE];
   operand_t             wake_j [RS_SIZE];
   operand_t             wake_k [RS_SIZE];
   operand_t             new_j;
   operand_t             new_k;
   logic [RS_SIZE-1:0]   busy_vec;
   logic [RS_SIZE-1:0]   cand_vec;
   logic [RS_IDX_W-1:0]  free_idx;
   logic [RS_IDX_W-1:0]  sel_idx;
   logic                 free_found;
   logic                 sel_found;

   // Occupancy and issue candidates come from registered state only, so no CDB-to-issue path exists.
   always_comb begin
      busy_vec = '0;
      cand_vec = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         busy_vec[i] = ent[i].busy;
         cand_vec[i] = ent[i].busy & ent[i].j_rdy & ent[i].k_rdy;
      end
   end

   assign bus.full = &busy_vec;

   rs_priority_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
      .req   (~busy_vec),
      .idx   (free_idx),
      .found (free_found)
   );

   rs_priority_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_sel_enc (
      .req   (cand_vec),
      .idx   (sel_idx),
      .found (sel_found)
   );

   // Per-entry wakeup values and the bypassed operands of the incoming micro-op.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         wake_j[i] = snoop(ent[i].j_rdy, ent[i].vj, ent[i].qj,
                           bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_data,
                           bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_data);
         wake_k[i] = snoop(ent[i].k_rdy, ent[i].vk, ent[i].qk,
                           bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_data,
                           bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_data);
      end
      new_j = snoop(bus.disp_j_rdy, bus.disp_vj, bus.disp_qj,
                    bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_data,
                    bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_data);
      new_k = snoop(bus.disp_k_rdy, bus.disp_vk, bus.disp_qk,
                    bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_data,
                    bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_data);
   end

   // Entry array and issue register: flush beats wakeup, issue and dispatch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            ent[i] <= '0;
         end
         bus.alu_ena     <= FALSE;
         bus.alu_op      <= '0;
         bus.alu_rob_tag <= '0;
         bus.alu_pc      <= ZERO_DATA;
         bus.alu_a       <= ZERO_DATA;
         bus.alu_b       <= ZERO_DATA;
         bus.alu_imm     <= ZERO_DATA;
      end else if (bus.flush) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            ent[i].busy <= FALSE;
         end
         bus.alu_ena <= FALSE;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (ent[i].busy) begin
               ent[i].j_rdy <= wake_j[i].rdy;
               ent[i].vj    <= wake_j[i].val;
               ent[i].k_rdy <= wake_k[i].rdy;
               ent[i].vk    <= wake_k[i].val;
            end
         end

         if (sel_found) begin
            bus.alu_ena         <= TRUE;
            bus.alu_op          <= ent[sel_idx].op;
            bus.alu_rob_tag     <= ent[sel_idx].rob_tag;
            bus.alu_pc          <= ent[sel_idx].pc;
            bus.alu_a           <= ent[sel_idx].vj;
            bus.alu_b           <= ent[sel_idx].vk;
            bus.alu_imm         <= ent[sel_idx].imm;
            ent[sel_idx].busy   <= FALSE;
         end else begin
            bus.alu_ena <= FALSE;
         end

         // The free slot is never busy, so it cannot collide with the wakeup or issue writes above.
         if (bus.disp_valid && free_found) begin
            ent[free_idx] <= '{busy:    TRUE,
                               op:      bus.disp_op,
                               pc:      bus.disp_pc,
                               imm:     bus.disp_imm,
                               rob_tag: bus.disp_rob_tag,
                               j_rdy:   new_j.rdy,
                               vj:      new_j.val,
                               qj:      bus.disp_qj,
                               k_rdy:   new_k.rdy,
                               vk:      new_k.val,
                               qk:      bus.disp_qk};
         end
      end
   end

endmodule
